fifo_rd_arbiter: RTL and testbench
==================================

Name: fifo_rd_arbiter

Overview:
- Downstream consumer of the sync FIFO core.
- Arbitrates among 8 destination channels by 8-bit priority and pops one 32-bit word per grant from the FIFO.
- Delivers the word on the granted channel's data bus with a one-cycle ready pulse.
- Instantiated inside top_wrapper between the FIFO read port and the data_dst0..7 / ready_dst0..7 outputs.

Parameters:
- NUM_CH, 8, number of destination channels; index width is clog2(NUM_CH).
- DATA_W, 32, FIFO word width.
- PRIO_W, 8, per-channel priority width.
- ADDR_W, 8, per-channel destination address width.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  FIFO pop strobe.
- fifo_rdata  input  DATA_W  FIFO read data, valid the cycle after fifo_rd_en.
- valid_dst  input  NUM_CH  per-channel request; bit i = channel i.
- priority_dst  input  NUM_CH*PRIO_W  packed priorities; channel i at [i*PRIO_W +: PRIO_W].
- addr_dst  input  NUM_CH*ADDR_W  packed destination addresses.
- data_dst  output  NUM_CH*DATA_W  packed per-channel delivered data.
- ready_dst  output  NUM_CH  per-channel one-cycle delivery pulse.
- grant_addr  output  ADDR_W  addr_dst of the most recent winner, for the data-correction stage.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; data_dst, ready_dst, grant_addr all 0.
  - Winner register 0; round-robin pointer last_grant=NUM_CH-1.
  - fifo_rd_en=0 during reset.
- FSM states: IDLE -> WAIT -> DELIVER -> IDLE.
- IDLE:
  - req = valid_dst != 0 && !fifo_empty.
  - fifo_rd_en = req; combinational, asserted only in IDLE.
  - If req, at the clock edge: latch winner index and its addr_dst into grant_addr, update last_grant=winner, go to WAIT.
  - Otherwise stay in IDLE.
- Winner selection:
  - Among channels with valid_dst=1, take the maximum priority value. Priority 0 is a legal, lowest priority.
  - Ties: take the first tied channel scanning upward from (last_grant+1) mod NUM_CH, with wrap-around.
- WAIT:
  - fifo_rdata holds the popped word.
  - At the edge: data_dst[winner] <= fifo_rdata; ready_dst[winner] <= 1; go to DELIVER.
- DELIVER:
  - ready_dst is one-hot for exactly one cycle.
  - At the edge: ready_dst <= 0; go to IDLE.
- Latency and throughput:
  - ready pulse appears 2 cycles after the fifo_rd_en cycle.
  - Maximum throughput is 1 word per 3 cycles.
- Holding rules:
  - data_dst[i] holds its value until channel i is granted again.
  - grant_addr holds until the next grant.
- Request changes:
  - valid_dst / priority_dst / addr_dst changes after the IDLE decision cycle are ignored; the grant completes.
  - Deassertion of the winner's valid mid-grant still yields delivery, because the word has already been popped.
- fifo_empty rising in WAIT/DELIVER has no effect. No pop is issued while fifo_empty=1.
- Reset asserted mid-grant: immediate return to IDLE with all outputs cleared. The popped word is lost; no ready pulse.
- Never more than one bit of ready_dst high. Never fifo_rd_en outside IDLE.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - state enumeration: IDLE=2'b00, WAIT=2'b01, DELIVER=2'b10.
  - NUM_CH, DATA_W, PRIO_W, ADDR_W defaults.
  - index-width constant.
- One combinational sub-module, arb_prio_sel: inputs valid, priorities, last_grant; output winner index plus any_valid. It is reused by the future write-side arbiter.

Test Plan:
- Reset check: hold reset_n=0 with valid_dst=8'hFF and fifo_empty=0 -> fifo_rd_en=0, ready_dst=0, data_dst=0. Release -> fifo_rd_en=1 in the first IDLE cycle.
- Strict priority: valid_dst=8'b0000_0101, priority ch0=3, ch2=9, FIFO word 32'hDEADBEEF -> fifo_rd_en one cycle, ready_dst=8'b0000_0100 two cycles later, data_dst ch2=32'hDEADBEEF, grant_addr=addr_dst2.
- Round-robin tie: all 8 channels valid, all priority 5, FIFO preloaded 0..7 -> grants in order ch0,ch1,...,ch7, then wrap to ch0; each ready pulse 3 cycles apart carries words 0..7.
- Empty FIFO: valid_dst=8'h10, fifo_empty=1 for 10 cycles -> no fifo_rd_en, state IDLE, busy=0. fifo_empty drops -> ch4 delivered 3 cycles later.
- Mid-grant valid drop: ch1 wins, valid_dst cleared during WAIT -> ready_dst[1] still pulses with popped word; other channels' data_dst unchanged.
- Reset during WAIT: assert reset_n=0 in WAIT -> same cycle all outputs 0, no ready pulse after release; next arbitration restarts with ch0 as first tie candidate.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizes for the FIFO-side channel arbiters.
// The read-side arbiter uses it now, and the write-side arbiter will use it later.
package fifo_arb_pkg;

   localparam int NUM_CH = 8;
   localparam int DATA_W = 32;
   localparam int PRIO_W = 8;
   localparam int ADDR_W = 8;
   localparam int IDX_W  = $clog2(NUM_CH);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      WAIT    = 2'b01,
      DELIVER = 2'b10
   } arb_state_t;

endpackage

// File: rtl/arb_prio_sel.sv
// Combinational highest-priority picker with round-robin tie-break starting after last_grant.
// Zero latency, with no flow control of its own; any_valid tells the caller whether winner is meaningful.
module arb_prio_sel #(
   parameter  int NUM_CH = 8,
   parameter  int PRIO_W = 8,
   localparam int IDX_W  = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0]        valid,
   input  logic [NUM_CH*PRIO_W-1:0] priorities,
   input  logic [IDX_W-1:0]         last_grant,
   output logic [IDX_W-1:0]         winner,
   output logic                     any_valid
);

   logic [PRIO_W-1:0] prio_a [NUM_CH];
   logic [PRIO_W-1:0] max_prio;
   logic [IDX_W-1:0]  cand;
   logic              found;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         prio_a[i] = priorities[i*PRIO_W +: PRIO_W];
      end

      // Priority 0 is legal, so any_valid is tracked separately from max_prio.
      max_prio  = '0;
      any_valid = |valid;
      for (int i = 0; i < NUM_CH; i++) begin
         if (valid[i] && (prio_a[i] > max_prio)) begin
            max_prio = prio_a[i];
         end
      end

      winner = '0;
      found  = 1'b0;
      cand   = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         cand = IDX_W'((int'(last_grant) + k) % NUM_CH);
         if (!found && valid[cand] && (prio_a[cand] == max_prio)) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Pops one FIFO word per grant and delivers it to the winning channel with a one-cycle ready pulse.
// The ready pulse comes 2 cycles after fifo_rd_en, for at most 1 word per 3 cycles; no pop is issued while the FIFO is empty.
module fifo_rd_arbiter #(
   parameter  int NUM_CH = fifo_arb_pkg::NUM_CH,
   parameter  int DATA_W = fifo_arb_pkg::DATA_W,
   parameter  int PRIO_W = fifo_arb_pkg::PRIO_W,
   parameter  int ADDR_W = fifo_arb_pkg::ADDR_W,
   localparam int IDX_W  = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     fifo_empty,
   output logic                     fifo_rd_en,
   input  logic [DATA_W-1:0]        fifo_rdata,
   input  logic [NUM_CH-1:0]        valid_dst,
   input  logic [NUM_CH*PRIO_W-1:0] priority_dst,
   input  logic [NUM_CH*ADDR_W-1:0] addr_dst,
   output logic [NUM_CH*DATA_W-1:0] data_dst,
   output logic [NUM_CH-1:0]        ready_dst,
   output logic [ADDR_W-1:0]        grant_addr,
   output logic                     busy
);

   import fifo_arb_pkg::*;

   arb_state_t        state_q, state_d;
   logic [IDX_W-1:0]  winner_q;
   logic [IDX_W-1:0]  last_grant_q;
   logic [IDX_W-1:0]  sel_winner;
   logic              any_valid;
   logic              req;
   logic              pop;
   logic [ADDR_W-1:0] sel_addr;

   arb_prio_sel #(
      .NUM_CH (NUM_CH),
      .PRIO_W (PRIO_W)
   ) u_sel (
      .valid      (valid_dst),
      .priorities (priority_dst),
      .last_grant (last_grant_q),
      .winner     (sel_winner),
      .any_valid  (any_valid)
   );

   assign req = any_valid && !fifo_empty;

   always_comb begin
      sel_addr = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (sel_winner == IDX_W'(i)) begin
            sel_addr = addr_dst[i*ADDR_W +: ADDR_W];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               pop     = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT:    state_d = DELIVER;
         DELIVER: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The async reset forces state to IDLE, so the pop is gated to stay low while reset is held.
   assign fifo_rd_en = pop && reset_n;
   assign busy       = (state_q != IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         winner_q     <= '0;
         last_grant_q <= IDX_W'(NUM_CH - 1);
         grant_addr   <= '0;
         data_dst     <= '0;
         ready_dst    <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (req) begin
                  winner_q     <= sel_winner;
                  last_grant_q <= sel_winner;
                  grant_addr   <= sel_addr;
               end
            end
            WAIT: begin
               for (int i = 0; i < NUM_CH; i++) begin
                  ready_dst[i] <= (winner_q == IDX_W'(i));
                  if (winner_q == IDX_W'(i)) begin
                     data_dst[i*DATA_W +: DATA_W] <= fifo_rdata;
                  end
               end
            end
            DELIVER: ready_dst <= '0;
            default: ready_dst <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Randomised and directed bench for fifo_rd_arbiter against a transaction-level model and a queue-based FIFO.
module tb_fifo_rd_arbiter;

   localparam int NUM_CH = 8;
   localparam int DATA_W = 32;
   localparam int PRIO_W = 8;
   localparam int ADDR_W = 8;

   logic                     clk = 1'b0;
   logic                     reset_n;
   logic                     fifo_empty;
   logic                     fifo_rd_en;
   logic [DATA_W-1:0]        fifo_rdata = '0;
   logic [NUM_CH-1:0]        valid_dst;
   logic [NUM_CH*PRIO_W-1:0] priority_dst;
   logic [NUM_CH*ADDR_W-1:0] addr_dst;
   logic [NUM_CH*DATA_W-1:0] data_dst;
   logic [NUM_CH-1:0]        ready_dst;
   logic [ADDR_W-1:0]        grant_addr;
   logic                     busy;

   int vectors    = 0;
   int miscompares = 0;

   logic [DATA_W-1:0] fq[$];
   int   pushes = 0;
   int   pops   = 0;
   logic force_empty = 1'b0;

   assign fifo_empty = force_empty || (pushes == pops);

   fifo_rd_arbiter dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .fifo_empty   (fifo_empty),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_rdata   (fifo_rdata),
      .valid_dst    (valid_dst),
      .priority_dst (priority_dst),
      .addr_dst     (addr_dst),
      .data_dst     (data_dst),
      .ready_dst    (ready_dst),
      .grant_addr   (grant_addr),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // FIFO read port: the popped word appears on fifo_rdata the cycle after the pop.
   always @(posedge clk) begin
      if (fifo_rd_en && (fq.size() > 0)) begin
         fifo_rdata <= fq.pop_front();
         pops       <= pops + 1;
      end
   end

   task automatic push_word(input logic [DATA_W-1:0] w);
      fq.push_back(w);
      pushes = pushes + 1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Highest priority wins; ties go to the first channel met scanning upward after the last grant.
   function automatic int model_pick(input logic [NUM_CH-1:0] v,
                                     input logic [NUM_CH*PRIO_W-1:0] p, input int last);
      int best = -1;
      int w    = -1;
      for (int k = 1; k <= NUM_CH; k++) begin
         int c;
         int pr;
         c  = (last + k) % NUM_CH;
         pr = int'(p[c*PRIO_W +: PRIO_W]);
         if (v[c] && pr > best) begin
            best = pr;
            w    = c;
         end
      end
      return w;
   endfunction

   int                       m_cnt  = 0;
   int                       m_last = NUM_CH - 1;
   int                       m_ch   = 0;
   logic [DATA_W-1:0]        m_word = '0;
   logic [ADDR_W-1:0]        m_addr = '0;
   logic [NUM_CH*DATA_W-1:0] m_data = '0;

   always @(negedge clk) begin
      logic [NUM_CH-1:0] onehot;
      logic              exp_rd;
      if (!reset_n) begin
         m_cnt  = 0;
         m_last = NUM_CH - 1;
         m_data = '0;
         m_addr = '0;
         check("rst_rd_en", fifo_rd_en, 0);
         check("rst_ready", ready_dst, 0);
         check("rst_data", data_dst, 0);
         check("rst_gaddr", grant_addr, 0);
         check("rst_busy", busy, 0);
      end else if (m_cnt > 0) begin
         check("busy_hi", busy, 1);
         check("rd_en_busy", fifo_rd_en, 0);
         if (m_cnt == 1) begin
            onehot       = '0;
            onehot[m_ch] = 1'b1;
            m_data[m_ch*DATA_W +: DATA_W] = m_word;
            check("ready_pulse", ready_dst, onehot);
         end else begin
            check("ready_wait", ready_dst, 0);
         end
         check("data_hold", data_dst, m_data);
         check("grant_addr", grant_addr, m_addr);
         m_cnt--;
      end else begin
         exp_rd = (valid_dst != '0) && !fifo_empty;
         check("busy_lo", busy, 0);
         check("ready_idle", ready_dst, 0);
         check("data_idle", data_dst, m_data);
         check("gaddr_idle", grant_addr, m_addr);
         check("rd_en", fifo_rd_en, exp_rd);
         if (exp_rd) begin
            m_ch   = model_pick(valid_dst, priority_dst, m_last);
            m_word = fq[0];
            m_addr = addr_dst[m_ch*ADDR_W +: ADDR_W];
            m_last = m_ch;
            m_cnt  = 2;
         end
      end
   end

   initial begin
      reset_n      = 1'b0;
      valid_dst    = 8'hFF;
      priority_dst = '0;
      addr_dst     = '0;
      for (int i = 0; i < NUM_CH; i++) addr_dst[i*ADDR_W +: ADDR_W] = ADDR_W'(8'hA0 + i);
      push_word(32'h1234_5678);
      repeat (4) step();
      reset_n = 1'b1;
      @(negedge clk);
      #1;
      check("rd_en_first_idle", fifo_rd_en, 1);
      step();
      valid_dst = '0;
      repeat (5) step();

      // Strict priority: ch2 (9) beats ch0 (3).
      valid_dst = 8'b0000_0101;
      priority_dst[0*PRIO_W +: PRIO_W] = 8'd3;
      priority_dst[2*PRIO_W +: PRIO_W] = 8'd9;
      push_word(32'hDEAD_BEEF);
      step();
      valid_dst = '0;
      step();
      check("prio_ready", ready_dst, 8'b0000_0100);
      check("prio_data", data_dst[2*DATA_W +: DATA_W], 32'hDEAD_BEEF);
      check("prio_gaddr", grant_addr, 8'hA2);
      repeat (3) step();

      // Empty FIFO holds off the pop.
      valid_dst   = 8'h10;
      force_empty = 1'b1;
      push_word(32'hCAFE_0004);
      for (int i = 0; i < 10; i++) begin
         step();
         check("empty_no_pop", fifo_rd_en, 0);
      end
      force_empty = 1'b0;
      repeat (3) step();
      check("empty_release", data_dst[4*DATA_W +: DATA_W], 32'hCAFE_0004);
      valid_dst = '0;
      repeat (3) step();

      // Winner drops valid during WAIT; the popped word is still delivered.
      valid_dst = 8'b0000_0010;
      push_word(32'h1111_2222);
      step();
      valid_dst = '0;
      step();
      check("drop_ready", ready_dst, 8'b0000_0010);
      check("drop_data", data_dst[1*DATA_W +: DATA_W], 32'h1111_2222);
      repeat (3) step();

      // Reset during WAIT clears everything immediately.
      valid_dst    = 8'hFF;
      priority_dst = {NUM_CH{8'd5}};
      push_word(32'h5555_AAAA);
      step();
      reset_n = 1'b0;
      #1;
      check("rstw_ready", ready_dst, 0);
      check("rstw_data", data_dst, 0);
      check("rstw_busy", busy, 0);
      check("rstw_gaddr", grant_addr, 0);
      valid_dst = '0;
      repeat (2) step();
      reset_n = 1'b1;
      repeat (3) step();

      // Round-robin among equal priorities starts from ch0 after reset.
      valid_dst = 8'hFF;
      for (int i = 0; i < NUM_CH; i++) push_word(DATA_W'(i));
      repeat (24) step();
      for (int i = 0; i < NUM_CH; i++) begin
         check($sformatf("rr_data%0d", i), data_dst[i*DATA_W +: DATA_W], DATA_W'(i));
      end
      valid_dst = '0;
      repeat (3) step();

      // Random traffic, checked cycle by cycle by the model.
      for (int n = 0; n < 2000; n++) begin
         valid_dst = NUM_CH'($urandom) & NUM_CH'($urandom);
         for (int i = 0; i < NUM_CH; i++) begin
            priority_dst[i*PRIO_W +: PRIO_W] = PRIO_W'($urandom_range(0, 3));
            addr_dst[i*ADDR_W +: ADDR_W]     = ADDR_W'($urandom);
         end
         if ($urandom_range(0, 2) == 0) push_word($urandom);
         force_empty = ($urandom_range(0, 7) == 0);
         reset_n     = ($urandom_range(0, 299) != 0);
         step();
      end
      reset_n     = 1'b1;
      force_empty = 1'b0;
      valid_dst   = '0;
      repeat (4) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
